reg_file_2r1w: RTL
==================

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data width in bits (multiple of 8, minimum 8).
REQ-002 The block SHALL have parameter DEPTH, default 8, number of entries (2..256, need not be a power of two).
REQ-003 The block SHALL have parameter BYPASS, default 1: 1 = write-first forwarding, 0 = read-old.
REQ-004 The block SHALL derive local AW = clog2(DEPTH), minimum 1, as address width.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-007 The block SHALL have port WrEn, input, 1, write request.
REQ-008 The block SHALL have port WrAddr, input, AW, write address.
REQ-009 The block SHALL have port WrData, input, WIDTH, write data.
REQ-010 The block SHALL have port WrStrb, input, WIDTH/8, byte write enables; bit i covers WrData[8i+7:8i].
REQ-011 The block SHALL have ports RdEnA and RdEnB, input, 1 each, read requests for ports A and B.
REQ-012 The block SHALL have ports RdAddrA and RdAddrB, input, AW each, read addresses.
REQ-013 The block SHALL have ports RdDataA and RdDataB, output, WIDTH each, registered read data.
REQ-014 The block SHALL have ports RdValidA and RdValidB, output, 1 each, one-cycle pulse qualifying RdDataA/B.
REQ-015 The block SHALL have port AddrErr, output, 1, one-cycle pulse for any out-of-range access.

Function
REQ-016 Write: on an edge with WrEn=1, WrAddr<DEPTH and rst=0, the block SHALL update only the bytes of entry[WrAddr] whose WrStrb bit is 1.
REQ-017 WrEn=1 with WrStrb all zero SHALL leave the memory unchanged and SHALL NOT raise AddrErr.
REQ-018 Read: on an edge with RdEnX=1, RdDataX SHALL load entry[RdAddrX] and RdValidX SHALL be 1 for the next cycle (latency 1).
REQ-019 With RdEnX=0, RdDataX SHALL hold its previous value and RdValidX SHALL be 0.
REQ-020 Ports A, B and the write port SHALL operate concurrently with no priority between them; any combination of enables is legal in the same cycle.
REQ-021 Same-cycle write and read of one address with BYPASS=1: RdDataX SHALL return the merged word (strobed bytes from WrData, other bytes from the old entry).
REQ-022 Same-cycle write and read of one address with BYPASS=0: RdDataX SHALL return the pre-write entry.
REQ-023 Both read ports addressing the same entry SHALL return identical data.
REQ-024 A write with WrAddr>=DEPTH SHALL be dropped.
REQ-025 A read with RdAddrX>=DEPTH SHALL load RdDataX=0 and still pulse RdValidX.
REQ-026 AddrErr SHALL be 1 in the cycle after any enabled access (write or read) had an address >=DEPTH; otherwise AddrErr SHALL be 0.
REQ-027 Addresses SHALL NOT wrap: an out-of-range address never aliases onto a valid entry.

Reset
REQ-028 While rst=1 at an edge, the block SHALL clear all DEPTH entries to 0, RdDataA/B to 0, RdValidA/B to 0 and AddrErr to 0.
REQ-029 Writes and reads requested in a cycle with rst=1 SHALL be ignored, including a request issued mid-sequence.
REQ-030 The first access SHALL be accepted on the first edge after rst falls, with no init latency.

Verification
REQ-031 Reset: rst=1 for 2 cycles, then read every address on A and B -> every RdData=0, RdValid pulsed, AddrErr=0.
REQ-032 Byte strobes: write 0xAE55 to addr 5 with WrStrb=11, then write 0x12FF with WrStrb=01, then read A at addr 5 -> 0xAE55 before the second write, 0xAEFF after it.
REQ-033 Concurrency and bypass: BYPASS=1, entry 3=0x1111; in one cycle write 0x4589 to addr 3, read A at addr 3 and B at addr 2 -> A=0x4589, B=0; repeat with BYPASS=0 -> A=0x1111.
REQ-034 Range: DEPTH=6; write 0xBEEF to addr 7, then read A at addr 7 and B at addr 7&3 -> AddrErr pulses on both cycles, A=0, B unchanged (no alias), RdValidA=1.
REQ-035 Reset mid-operation: write 0x0025 to addr 4 in the cycle rst=1, release rst, read addr 4 -> 0x0000; the same write after release reads back 0x0025.
REQ-036 Hold: read addr 5 (0xAE55), then drop RdEnA for 3 cycles while writing addr 5 -> RdDataA stays 0xAE55 and RdValidA=0 throughout.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with byte strobes, registered reads,
// optional write-first forwarding and out-of-range address detection.
module reg_file_2r1w_rd #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int BYPASS = 1,
   parameter int AW     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   input  logic [WIDTH-1:0] mem_word,
   input  logic             wr_ok,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_merged,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             rd_err
);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic             in_range;
   logic [WIDTH-1:0] next_word;

   always_comb begin
      in_range = ({1'b0, rd_addr} < DEPTH_W);
      rd_err   = rd_en & ~in_range;
      // Out-of-range reads return zero rather than aliasing onto a real entry.
      if (!in_range)
         next_word = '0;
      else if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr))
         next_word = wr_merged;
      else
         next_word = mem_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= next_word;
      end
   end
endmodule

module reg_file_2r1w #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int BYPASS = 1,
   localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               WrEn,
   input  logic [AW-1:0]      WrAddr,
   input  logic [WIDTH-1:0]   WrData,
   input  logic [WIDTH/8-1:0] WrStrb,
   input  logic               RdEnA,
   input  logic               RdEnB,
   input  logic [AW-1:0]      RdAddrA,
   input  logic [AW-1:0]      RdAddrB,
   output logic [WIDTH-1:0]   RdDataA,
   output logic [WIDTH-1:0]   RdDataB,
   output logic               RdValidA,
   output logic               RdValidB,
   output logic               AddrErr
);
   localparam int          NB      = WIDTH / 8;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_in_range, wr_ok, wr_err;
   logic [WIDTH-1:0] wr_old, wr_merged;

   logic [1:0]            rd_en_v, rd_valid_v, rd_err_v;
   logic [1:0][AW-1:0]    rd_addr_v;
   logic [1:0][WIDTH-1:0] rd_word_v, rd_data_v;

   always_comb begin
      wr_in_range = ({1'b0, WrAddr} < DEPTH_W);
      wr_ok       = WrEn & wr_in_range;
      // An all-zero strobe is not an access, so it cannot flag an error.
      wr_err      = WrEn & (|WrStrb) & ~wr_in_range;
      wr_old      = wr_in_range ? mem[WrAddr] : '0;
      wr_merged   = wr_old;
      for (int i = 0; i < NB; i++)
         if (WrStrb[i]) wr_merged[8*i +: 8] = WrData[8*i +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
         AddrErr <= 1'b0;
      end else begin
         if (wr_ok)
            for (int i = 0; i < NB; i++)
               if (WrStrb[i]) mem[WrAddr][8*i +: 8] <= WrData[8*i +: 8];
         AddrErr <= wr_err | (|rd_err_v);
      end
   end

   assign rd_en_v   = {RdEnB, RdEnA};
   assign rd_addr_v = {RdAddrB, RdAddrA};

   for (genvar p = 0; p < 2; p++) begin : g_rd
      assign rd_word_v[p] = mem[rd_addr_v[p]];
      reg_file_2r1w_rd #(
         .WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .AW(AW)
      ) u_rd (
         .clk      (clk),
         .rst      (rst),
         .rd_en    (rd_en_v[p]),
         .rd_addr  (rd_addr_v[p]),
         .mem_word (rd_word_v[p]),
         .wr_ok    (wr_ok),
         .wr_addr  (WrAddr),
         .wr_merged(wr_merged),
         .rd_data  (rd_data_v[p]),
         .rd_valid (rd_valid_v[p]),
         .rd_err   (rd_err_v[p])
      );
   end

   assign RdDataA  = rd_data_v[0];
   assign RdDataB  = rd_data_v[1];
   assign RdValidA = rd_valid_v[0];
   assign RdValidB = rd_valid_v[1];
endmodule
